sm_cpu_mc: RTL and testbench



---
 rtl/sm_cpu_mc_pkg.sv | 29 ++
 rtl/sm_mc_alu.sv | 26 ++
 rtl/sm_cpu_mc.sv | 136 +++++++++++++
 tb/tb_sm_cpu_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sm_cpu_mc_pkg.sv
// sm_cpu_mc_pkg: opcode/funct encodings, ALU operations and FSM states for the multicycle core
package sm_cpu_mc_pkg;
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] FN_SRL    = 6'h02;
   localparam logic [5:0] FN_SLLV   = 6'h04;
   localparam logic [5:0] FN_ADDU   = 6'h21;
   localparam logic [5:0] FN_SUBU   = 6'h23;
   localparam logic [5:0] FN_OR     = 6'h25;
   localparam logic [5:0] FN_NOR    = 6'h27;
   localparam logic [5:0] FN_SLTU   = 6'h2B;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLTU, ALU_SRL, ALU_SLLV, ALU_LUI} alu_op_t;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, LOAD, WB} state_t;
   function automatic alu_op_t funct_op(input logic [5:0] fn);
      return fn == FN_SUBU ? ALU_SUB :
             fn == FN_OR   ? ALU_OR  :
             fn == FN_NOR  ? ALU_NOR :
             fn == FN_SLTU ? ALU_SLTU :
             fn == FN_SRL  ? ALU_SRL :
             fn == FN_SLLV ? ALU_SLLV : ALU_ADD;
   endfunction
endpackage

// File: rtl/sm_mc_alu.sv
// sm_mc_alu: combinational 32-bit ALU, wrap-around arithmetic, unsigned compare
module sm_mc_alu
   import sm_cpu_mc_pkg::*;
(
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  alu_op_t     oper,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        zero
);
   always_comb begin
      case (oper)
         ALU_ADD:  result = srcA + srcB;
         ALU_SUB:  result = srcA - srcB;
         ALU_OR:   result = srcA | srcB;
         ALU_NOR:  result = ~(srcA | srcB);
         ALU_SLTU: result = {31'd0, srcA < srcB};
         ALU_SRL:  result = srcB >> shamt;
         ALU_SLLV: result = srcB << srcA[4:0];
         ALU_LUI:  result = {srcB[15:0], 16'd0};
         default:  result = srcA ^ srcB;
      endcase
   end
   assign zero = result == 32'd0;
endmodule

// File: rtl/sm_cpu_mc.sv
// sm_cpu_mc: multicycle schoolMIPS core with handshaked fetch and blocking external-input loads
module sm_cpu_mc
   import sm_cpu_mc_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'd0,
   parameter int          EXT_CH   = 4,
   parameter int          EXT_W    = 8
)(
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    im_req,
   output logic [31:0]             im_addr,
   input  logic                    im_rdy,
   input  logic [31:0]             im_data,
   input  logic [EXT_CH*EXT_W-1:0] ext_data,
   input  logic [EXT_CH-1:0]       ext_valid,
   output logic [EXT_CH-1:0]       ext_ack,
   input  logic [4:0]              regAddr,
   output logic [31:0]             regData,
   output logic                    instr_done
);
   state_t state;
   logic [31:0] pc, instr, A, B, aluOut;
   logic [31:0] rf [0:31];
   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd, sh, wa;
   logic [31:0] simm, zimm, alu_b, alu_res;
   logic is_r, is_addiu, is_xori, is_lui, is_beq, is_bne, is_bgez, is_lw, is_br, supported;
   logic alu_zero, taken, in_range, ext_hit;
   logic signed [EXT_W-1:0] ext_sel;
   alu_op_t alu_op;

   assign op   = instr[31:26];
   assign rs   = instr[25:21];
   assign rt   = instr[20:16];
   assign rd   = instr[15:11];
   assign sh   = instr[10:6];
   assign fn   = instr[5:0];
   assign simm = {{16{instr[15]}}, instr[15:0]};
   assign zimm = {16'd0, instr[15:0]};

   assign is_r      = (op == OP_RTYPE) && (fn inside {FN_ADDU, FN_SUBU, FN_OR, FN_NOR, FN_SLTU, FN_SRL, FN_SLLV});
   assign is_addiu  = op == OP_ADDIU;
   assign is_xori   = op == OP_XORI;
   assign is_lui    = op == OP_LUI;
   assign is_beq    = op == OP_BEQ;
   assign is_bne    = op == OP_BNE;
   assign is_bgez   = (op == OP_REGIMM) && (rt == RT_BGEZ);
   assign is_lw     = op == OP_LW;
   assign is_br     = is_beq | is_bne | is_bgez;
   assign supported = is_r | is_addiu | is_xori | is_lui | is_br | is_lw;

   assign alu_op = is_r ? funct_op(fn) : is_xori ? ALU_XOR : is_lui ? ALU_LUI : is_br ? ALU_SUB : ALU_ADD;
   assign alu_b  = (is_r || is_br) ? B : (is_xori || is_lui) ? zimm : simm;

   sm_mc_alu u_alu (
      .srcA   (A),
      .srcB   (alu_b),
      .oper   (alu_op),
      .shamt  (sh),
      .result (alu_res),
      .zero   (alu_zero)
   );

   assign taken = (is_beq & alu_zero) | (is_bne & ~alu_zero) | (is_bgez & ~A[31]);

   // aluOut holds the channel index while in LOAD; only an exact in-range match can ack
   always_comb begin
      ext_sel = '0;
      ext_ack = '0;
      for (int c = 0; c < EXT_CH; c++)
         if (aluOut == 32'(c)) begin
            ext_sel    = ext_data[c*EXT_W +: EXT_W];
            ext_ack[c] = (state == LOAD) && ext_valid[c];
         end
   end
   assign in_range = aluOut < 32'(EXT_CH);
   assign ext_hit  = |ext_ack;

   function automatic logic [31:0] rd_rf(input logic [4:0] a);
      return a == 5'd0 ? 32'd0 : rf[a];
   endfunction

   assign im_req     = state == FETCH;
   assign im_addr    = pc;
   assign regData    = regAddr == 5'd0 ? pc : rf[regAddr];
   assign instr_done = (state == WB) || ((state == EXEC) && is_br) || ((state == DECODE) && !supported);
   assign wa         = is_r ? rd : rt;

   always_ff @(posedge clk)
      if (state == WB && wa != 5'd0) rf[wa] <= aluOut;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= PC_RESET;
         instr  <= '0;
         A      <= '0;
         B      <= '0;
         aluOut <= '0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH:
               if (im_rdy) begin
                  instr <= im_data;
                  pc    <= pc + 32'd1;
                  state <= DECODE;
               end
            DECODE: begin
               A     <= rd_rf(rs);
               B     <= rd_rf(rt);
               state <= supported ? EXEC : FETCH;
            end
            EXEC: begin
               aluOut <= alu_res;
               if (is_br) begin
                  if (taken) pc <= pc + simm;
                  state <= FETCH;
               end else
                  state <= is_lw ? LOAD : WB;
            end
            LOAD:
               if (!in_range) begin
                  aluOut <= '0;
                  state  <= WB;
               end else if (ext_hit) begin
                  aluOut <= 32'(ext_sel);
                  state  <= WB;
               end
            WB: state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sm_cpu_mc.sv
// tb_sm_cpu_mc: scoreboarded bench; expected retire latencies queued at fetch, popped on instr_done
module tb_sm_cpu_mc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        im_req, im_rdy, instr_done;
   logic [31:0] im_addr, im_data, regData, ext_data;
   logic [3:0]  ext_valid, ext_ack;
   logic [4:0]  regAddr;

   always #5 clk = ~clk;

   sm_cpu_mc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_rdy     (im_rdy),
      .im_data    (im_data),
      .ext_data   (ext_data),
      .ext_valid  (ext_valid),
      .ext_ack    (ext_ack),
      .regAddr    (regAddr),
      .regData    (regData),
      .instr_done (instr_done)
   );

   typedef struct {string name; int lat;} exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0, cyc = 0, t_acc = 0, done_cnt = 0, ack_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // latency counts the accepting FETCH cycle as cycle 1
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (im_req && im_rdy) t_acc = cyc;
      if (ext_ack != 4'd0) begin
         ack_cnt++;
         chk("ack_onehot", $countones(ext_ack), 1);
      end
      if (instr_done) begin
         done_cnt++;
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else begin
            e = sb.pop_front();
            chk({e.name, "_lat"}, cyc - t_acc + 1, e.lat);
         end
      end
   end

   function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string name, input logic [31:0] ins, input int lat, input logic [31:0] addr, input int waits);
      int n = 0;
      while (!im_req && n < 50) begin
         tick();
         n++;
      end
      chk({name, "_req"}, {31'd0, im_req}, 1);
      chk({name, "_addr"}, im_addr, addr);
      for (int i = 0; i < waits; i++) begin
         tick();
         chk({name, "_hold_req"}, {31'd0, im_req}, 1);
         chk({name, "_hold_addr"}, im_addr, addr);
      end
      sb.push_back('{name, lat});
      im_data = ins;
      im_rdy  = 1'b1;
      tick();
      im_rdy  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 40) begin
         tick();
         n++;
      end
      chk({name, "_done"}, done_cnt - d0, 1);
   endtask

   task automatic run(input string name, input logic [31:0] ins, input int lat, input logic [31:0] addr, input int waits);
      int d0 = done_cnt;
      fetch(name, ins, lat, addr, waits);
      wait_done(name, d0);
   endtask

   task automatic rchk(input logic [4:0] r, input logic [31:0] exp);
      regAddr = r;
      #1;
      chk($sformatf("r%0d", r), regData, exp);
      regAddr = 5'd0;
   endtask

   initial begin
      int d0, n;
      im_rdy = 1'b0; im_data = '0; ext_data = '0; ext_valid = '0; regAddr = 5'd0;
      repeat (2) tick();
      chk("rst_req", {31'd0, im_req}, 0);
      chk("rst_done", {31'd0, instr_done}, 0);
      chk("rst_ack", ext_ack, 0);
      chk("rst_pc", regData, 0);
      rst_n = 1'b1;

      run("addiu1", ri(6'h09, 0, 1, 16'd5),    4, 0, 3);
      run("addiu2", ri(6'h09, 0, 2, 16'hFFFD), 4, 1, 0);
      run("addu3",  rr(1, 2, 3, 0, 6'h21),     4, 2, 0);
      run("sltu4",  rr(2, 1, 4, 0, 6'h2B),     4, 3, 0);
      rchk(1, 32'd5);
      rchk(3, 32'd2);
      rchk(4, 32'd0);
      run("srl9",   rr(0, 2, 9, 28, 6'h02),    4, 4, 0);
      run("sllv10", rr(1, 1, 10, 0, 6'h04),    4, 5, 0);
      run("subu11", rr(1, 2, 11, 0, 6'h23),    4, 6, 0);
      run("or12",   rr(1, 2, 12, 0, 6'h25),    4, 7, 0);
      run("nor13",  rr(0, 1, 13, 0, 6'h27),    4, 8, 0);
      run("lui14",  ri(6'h0F, 0, 14, 16'h1234), 4, 9, 0);
      run("clr1",   ri(6'h09, 0, 1, 16'd0),    4, 10, 0);
      run("bgez",   ri(6'h01, 1, 1, 16'd2),    3, 11, 0);
      run("beq",    ri(6'h04, 1, 0, 16'hFFFF), 3, 14, 0);
      run("bne",    ri(6'h05, 1, 0, 16'd5),    3, 14, 0);
      run("unsup",  32'hFC00_0000,             2, 15, 0);
      run("wr_r0",  ri(6'h09, 0, 0, 16'd7),    4, 16, 0);

      d0 = done_cnt;
      ext_data = 32'h0000_0011;
      ext_valid = 4'b0001;
      fetch("lw5", ri(6'h23, 0, 5, 16'd1), 8, 17, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("lw5_noack", ext_ack, 0);
      end
      ext_data[15:8] = 8'hF0;
      ext_valid = 4'b0011;
      #1;
      chk("lw5_ack", ext_ack, 4'b0010);
      tick();
      ext_valid = 4'b0000;
      chk("lw5_ack_end", ext_ack, 0);
      wait_done("lw5", d0);
      chk("ack_cnt_lw5", ack_cnt, 1);

      ext_valid = 4'hF;
      run("lw6", ri(6'h23, 0, 6, 16'd7), 5, 18, 0);
      ext_valid = 4'h0;
      chk("ack_cnt_lw6", ack_cnt, 1);

      fetch("lw3", ri(6'h23, 0, 3, 16'd2), 0, 19, 0);
      repeat (3) tick();
      chk("lw3_wait_noack", ext_ack, 0);
      rst_n = 1'b0;
      ext_valid = 4'hF;
      #1;
      chk("arst_req", {31'd0, im_req}, 0);
      chk("arst_ack", ext_ack, 0);
      chk("arst_done", {31'd0, instr_done}, 0);
      chk("arst_pc", regData, 0);
      sb.delete();
      repeat (2) tick();
      chk("arst_hold_ack", ext_ack, 0);
      rst_n = 1'b1;
      ext_valid = 4'h0;
      run("xori7", ri(6'h0E, 0, 7, 16'hFFFF), 4, 0, 0);
      n = 0;
      while (!im_req && n < 50) begin
         tick();
         n++;
      end
      chk("final_addr", im_addr, 1);

      rchk(1, 32'd0);
      rchk(2, 32'hFFFF_FFFD);
      rchk(3, 32'd2);
      rchk(5, 32'hFFFF_FFF0);
      rchk(6, 32'd0);
      rchk(7, 32'h0000_FFFF);
      rchk(9, 32'h0000_000F);
      rchk(10, 32'h0000_00A0);
      rchk(11, 32'd8);
      rchk(12, 32'hFFFF_FFFD);
      rchk(13, 32'hFFFF_FFFA);
      rchk(14, 32'h1234_0000);
      chk("ack_total", ack_cnt, 1);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
